wavelet_mac_sequencer: RTL and testbench

//  Time-multiplexes one signed 8x8 multiply-accumulate unit across all Ricker FIR filters, replacing per-filter parallel MACs.

---
 rtl/wavelet_mac_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_wavelet_mac_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wavelet_mac_sequencer.sv
// wavelet_mac_sequencer
// Shares one signed 8x8 multiply-accumulate unit across all Ricker FIR
// filters. A synchronised sample strobe triggers a tap shift, then every
// filter's taps are read one per cycle through an external tap/coef port.
// Each filter's truncated sum is latched into its slot of the packed
// o_wavelet bus.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a sample strobe or a pending strobe
// SHIFT  | one-cycle o_shift pulse, filter index reset to 0
// RUN    | one tap/coef read per cycle for the current filter
// DRAIN  | no read; the data of the last read is accumulated
// STORE  | truncated sum written to the filter's slot, acc cleared
// DONE   | one-cycle o_done pulse; restart if a strobe is pending
module wavelet_mac_sequencer #(
   parameter int BITS_PER_ELEM  = 8,
   parameter int NUM_FILTERS    = 8,
   parameter int SUM_TRUNCATION = 8,
   parameter int ACC_BITS       = 24,
   parameter int TAP_IDX_BITS   = 8,
   // taps per filter, 8 bits each, filter0 in LSB: 3,5,9,15,27,47,81,141
   parameter logic [NUM_FILTERS*8-1:0] FILTER_LENS = 64'h8D512F1B0F090503,
   // sum MSB+1 per filter, 5 bits each, filter0 in LSB: 16,16,17,18,18,19,20,21
   parameter logic [NUM_FILTERS*5-1:0] FILTER_MSB  = 40'hAD27294610
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  i_data_clk,
   output logic                                  o_shift,
   output logic                                  o_rd_en,
   output logic [$clog2(NUM_FILTERS)-1:0]        o_filter_idx,
   output logic [TAP_IDX_BITS-1:0]               o_tap_idx,
   input  logic [BITS_PER_ELEM-1:0]              i_tap,
   input  logic [BITS_PER_ELEM-1:0]              i_coef,
   output logic [NUM_FILTERS*SUM_TRUNCATION-1:0] o_wavelet,
   output logic                                  o_busy,
   output logic                                  o_done,
   output logic                                  o_overrun
);

   localparam int FIDX_BITS = $clog2(NUM_FILTERS);
   localparam int PROD_BITS = 2 * BITS_PER_ELEM;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_RUN,
      S_DRAIN,
      S_STORE,
      S_DONE
   } state_t;

   state_t                               state_q, state_d;
   logic [2:0]                           sync_q, sync_d;
   logic                                 pending_q, pending_d;
   logic                                 overrun_q, overrun_d;
   logic [FIDX_BITS-1:0]                 f_q, f_d;
   logic [TAP_IDX_BITS-1:0]              idx_q, idx_d;
   logic                                 shift_q, shift_d;
   logic                                 rd_en_q, rd_en_d;
   logic                                 rd_dly_q, rd_dly_d;
   logic                                 busy_q, busy_d;
   logic                                 done_q, done_d;
   logic [ACC_BITS-1:0]                  acc_q, acc_d;
   logic [NUM_FILTERS*SUM_TRUNCATION-1:0] wavelet_q, wavelet_d;

   logic                                 strobe_edge;
   logic [TAP_IDX_BITS-1:0]              len_f;
   logic [4:0]                           msb_f;
   logic [4:0]                           shamt;
   logic                                 last_tap;
   logic [PROD_BITS-1:0]                 tap_x, coef_x, prod;
   logic [ACC_BITS-1:0]                  prod_x;
   logic [SUM_TRUNCATION-1:0]            slot_val;

   // Rising edge of the synchronised strobe (third flop holds the previous level).
   assign strobe_edge = sync_q[1] & ~sync_q[2];

   // Per-filter length and sum-MSB lookup for the filter currently addressed.
   always_comb begin
      len_f = '0;
      msb_f = '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
         if (f_q == FIDX_BITS'(i)) begin
            len_f = TAP_IDX_BITS'(FILTER_LENS[i*8 +: 8]);
            msb_f = FILTER_MSB[i*5 +: 5];
         end
      end
   end

   assign last_tap = (idx_q == len_f - 1'b1);

   // Sequencer next state, strobe bookkeeping and tap/filter counters.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      f_d       = f_q;
      idx_d     = idx_q;
      sync_d    = {sync_q[1:0], i_data_clk};
      case (state_q)
         S_IDLE: begin
            if (strobe_edge || pending_q) begin
               state_d   = S_SHIFT;
               // both present: one starts this pass, the other stays queued
               pending_d = strobe_edge & pending_q;
            end
         end
         S_SHIFT: begin
            state_d = S_RUN;
            f_d     = '0;
            idx_d   = '0;
         end
         S_RUN: begin
            if (last_tap) begin
               state_d = S_DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DRAIN: begin
            state_d = S_STORE;
         end
         S_STORE: begin
            if (f_q == FIDX_BITS'(NUM_FILTERS - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
               f_d     = f_q + 1'b1;
               idx_d   = '0;
            end
         end
         S_DONE: begin
            state_d   = pending_q ? S_SHIFT : S_IDLE;
            // a pending strobe is consumed here, so a new edge only queues
            pending_d = strobe_edge;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (strobe_edge && (state_q != S_IDLE) && (state_q != S_DONE)) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end
   end

   // Output strobes are registered from the next state so they align with it.
   always_comb begin
      shift_d  = (state_d == S_SHIFT);
      rd_en_d  = (state_d == S_RUN);
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
      rd_dly_d = rd_en_q;
   end

   // Sign-extended product; the low 16 bits of the widened unsigned
   // multiply equal the signed 8x8 product.
   always_comb begin
      tap_x  = {{BITS_PER_ELEM{i_tap[BITS_PER_ELEM-1]}}, i_tap};
      coef_x = {{BITS_PER_ELEM{i_coef[BITS_PER_ELEM-1]}}, i_coef};
      prod   = tap_x * coef_x;
      prod_x = {{(ACC_BITS-PROD_BITS){prod[PROD_BITS-1]}}, prod};
   end

   // Accumulate the data returned one cycle after each read; clear on store.
   always_comb begin
      acc_d = acc_q;
      if (rd_dly_q) begin
         acc_d = acc_q + prod_x;
      end
      if (state_q == S_STORE) begin
         acc_d = '0;
      end
   end

   // Truncated slice acc[MSB-1 -: SUM_TRUNCATION]; wraps, no saturation.
   always_comb begin
      shamt    = msb_f - 5'(SUM_TRUNCATION);
      slot_val = SUM_TRUNCATION'(acc_q >> shamt);
   end

   // Only the current filter's slot changes on STORE; the others hold.
   always_comb begin
      wavelet_d = wavelet_q;
      if (state_q == S_STORE) begin
         for (int i = 0; i < NUM_FILTERS; i++) begin
            if (f_q == FIDX_BITS'(i)) begin
               wavelet_d[i*SUM_TRUNCATION +: SUM_TRUNCATION] = slot_val;
            end
         end
      end
   end

   // All state flops; synchronous reset abandons any pass in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sync_q    <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         f_q       <= '0;
         idx_q     <= '0;
         shift_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_dly_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         acc_q     <= '0;
         wavelet_q <= '0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         f_q       <= f_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rd_en_q   <= rd_en_d;
         rd_dly_q  <= rd_dly_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         acc_q     <= acc_d;
         wavelet_q <= wavelet_d;
      end
   end

   assign o_shift      = shift_q;
   assign o_rd_en      = rd_en_q;
   assign o_filter_idx = f_q;
   assign o_tap_idx    = idx_q;
   assign o_wavelet    = wavelet_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_wavelet_mac_sequencer.sv
// Directed bench for wavelet_mac_sequencer: constant tap/coef data so each
// filter sum is len_f * tap * coef, with hand-computed truncated slots.
module tb_wavelet_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_data_clk;
   logic        o_shift;
   logic        o_rd_en;
   logic [2:0]  o_filter_idx;
   logic [7:0]  o_tap_idx;
   logic [7:0]  i_tap;
   logic [7:0]  i_coef;
   logic [63:0] o_wavelet;
   logic        o_busy;
   logic        o_done;
   logic        o_overrun;

   int errors    = 0;
   int checks    = 0;
   int shift_cnt = 0;
   int lens [0:7] = '{3, 5, 9, 15, 27, 47, 81, 141};

   wavelet_mac_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .i_data_clk   (i_data_clk),
      .o_shift      (o_shift),
      .o_rd_en      (o_rd_en),
      .o_filter_idx (o_filter_idx),
      .o_tap_idx    (o_tap_idx),
      .i_tap        (i_tap),
      .i_coef       (i_coef),
      .o_wavelet    (o_wavelet),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_overrun    (o_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (o_shift) shift_cnt++;
   endtask

   task automatic wait_shift(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!o_shift && lat < 20);
   endtask

   // Starts on the o_shift cycle (n=0) and follows the pass to o_done.
   task automatic run_pass(input int s2, input int s3, output int done_n, output int rd_cnt,
                           output bit trace_ok, output logic [63:0] snap10, output logic ov150);
      int ef, ei, last;
      done_n = -1; rd_cnt = 0; trace_ok = 1'b1; snap10 = '0; ov150 = 1'b0;
      ef = 0; ei = 0; last = 0;
      for (int n = 0; n <= 400; n++) begin
         if (n == 10)  snap10 = o_wavelet;
         if (n == 150) ov150 = o_overrun;
         if (o_rd_en) begin
            rd_cnt++;
            if (ef > 7 || o_filter_idx !== 3'(ef) || o_tap_idx !== 8'(ei)) trace_ok = 1'b0;
            if (n - last != ((ei == 0 && ef > 0) ? 3 : 1)) trace_ok = 1'b0;
            last = n;
            ei++;
            if (ef < 8 && ei == lens[ef]) begin
               ef++;
               ei = 0;
            end
         end
         if (o_done) begin
            done_n = n;
            break;
         end
         if (n == s2 || n == s3) i_data_clk = 1'b1;
         if (n == s2 + 4 || n == s3 + 4) i_data_clk = 1'b0;
         tick();
      end
      if (ef != 8) trace_ok = 1'b0;
   endtask

   initial begin
      int          lat, done_n, rd_cnt;
      bit          trace_ok, bad;
      logic [63:0] snap10;
      logic        ov150;

      rst = 1'b1; i_data_clk = 1'b0; i_tap = '0; i_coef = '0;
      repeat (3) tick();
      check("rst_wavelet", o_wavelet, 64'h0);
      check("rst_busy",    64'(o_busy), 64'h0);
      check("rst_shift",   64'(o_shift), 64'h0);
      check("rst_done",    64'(o_done), 64'h0);
      check("rst_overrun", 64'(o_overrun), 64'h0);
      check("rst_rd_en",   64'(o_rd_en), 64'h0);

      rst = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (o_rd_en || o_busy) bad = 1'b1;
      end
      check("idle_no_read", 64'(bad), 64'h0);

      // pass 1: taps 127*127, second strobe at 100 (pending), third at 200 (dropped)
      i_tap = 8'd127; i_coef = 8'd127; shift_cnt = 0;
      i_data_clk = 1'b1;
      wait_shift(lat);
      check("shift_latency", 64'(lat), 64'd3);
      i_data_clk = 1'b0;
      run_pass(100, 200, done_n, rd_cnt, trace_ok, snap10, ov150);
      check("p1_done_cycle", 64'(done_n), 64'd345);
      check("p1_rd_count",   64'(rd_cnt), 64'd328);
      check("p1_trace",      64'(trace_ok), 64'h1);
      check("p1_wavelet",    o_wavelet, 64'h153E72A9EC1B3BBD);
      check("p1_ovr_mid",    64'(ov150), 64'h0);
      check("p1_ovr_end",    64'(o_overrun), 64'h1);

      // pass 2 starts straight from DONE because of the pending strobe
      tick();
      check("p2_restart_shift", 64'(o_shift), 64'h1);
      check("p2_done_cleared",  64'(o_done), 64'h0);
      i_tap = 8'h80; i_coef = 8'd127;
      run_pass(-1, -1, done_n, rd_cnt, trace_ok, snap10, ov150);
      check("p2_done_cycle", 64'(done_n), 64'd345);
      check("p2_trace",      64'(trace_ok), 64'h1);
      check("p2_mid_slot0",  64'(snap10[7:0]), 64'h41);
      check("p2_mid_slot7",  64'(snap10[63:56]), 64'h15);
      check("p2_slot0",      64'(o_wavelet[7:0]), 64'h41);
      check("p2_slot7",      64'(o_wavelet[63:56]), 64'hE8);
      repeat (30) tick();
      check("two_passes_only", 64'(shift_cnt), 64'd2);
      check("idle_after_p2",   64'(o_busy), 64'h0);
      check("overrun_sticky",  64'(o_overrun), 64'h1);

      // reset 50 cycles into a pass
      i_data_clk = 1'b1;
      wait_shift(lat);
      i_data_clk = 1'b0;
      repeat (50) tick();
      rst = 1'b1;
      tick();
      check("mid_rst_wavelet", o_wavelet, 64'h0);
      check("mid_rst_busy",    64'(o_busy), 64'h0);
      check("mid_rst_rd_en",   64'(o_rd_en), 64'h0);
      check("mid_rst_overrun", 64'(o_overrun), 64'h0);
      check("mid_rst_shift",   64'(o_shift), 64'h0);
      check("mid_rst_done",    64'(o_done), 64'h0);
      rst = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (o_rd_en || o_busy) bad = 1'b1;
      end
      check("post_rst_idle", 64'(bad), 64'h0);

      // clean pass after the reset
      i_tap = 8'd127; i_coef = 8'd127;
      i_data_clk = 1'b1;
      wait_shift(lat);
      check("p3_shift_latency", 64'(lat), 64'd3);
      i_data_clk = 1'b0;
      run_pass(-1, -1, done_n, rd_cnt, trace_ok, snap10, ov150);
      check("p3_done_cycle", 64'(done_n), 64'd345);
      check("p3_rd_count",   64'(rd_cnt), 64'd328);
      check("p3_trace",      64'(trace_ok), 64'h1);
      check("p3_wavelet",    o_wavelet, 64'h153E72A9EC1B3BBD);
      check("p3_overrun",    64'(o_overrun), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
